// File: rtl/mod_sub_serial.sv
// -----------------------------------------------------------------------------
// mod_sub_serial
//
// Digit-serial modular subtractor: d = (a - b) mod p for ECC field operands.
// One DIGIT-bit slice of the operands is processed per clock, least
// significant digit first, with a registered borrow/carry. When the raw
// difference underflows, a second digit-serial pass adds p back.
//
// Optional build macro: MODSUB_CONST_TIME_EN
//   undefined : the correction pass is skipped when there is no underflow,
//               so latency is N+1 (a >= b) or 2N+1 (a < b) cycles.
//   defined   : the correction pass always runs (adding p or 0), so latency
//               is always 2N+1 cycles regardless of the operand values.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   a, b, p are presented
//   in_ready   out  block is idle and will accept operands
//   a, b, p    in   minuend, subtrahend, modulus (WIDTH bits)
//   out_valid  out  d / corr hold a finished result
//   out_ready  in   consumer takes the result
//   d          out  result (WIDTH bits)
//   corr       out  1 when p was added back (a < b)
// -----------------------------------------------------------------------------
module mod_sub_serial #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DIGIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             corr
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;     // borrow in SUB, carry in FIX
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             corr_q, corr_d;

    logic [DIGIT:0]   sub_t;            // {borrow_out, difference digit}
    logic [DIGIT:0]   add_t;            // {carry_out, sum digit}
    logic [DIGIT-1:0] p_add;

    // Digit of p added during the correction pass. In constant-time builds
    // the pass always runs, so the addend is masked by the underflow flag.
`ifdef MODSUB_CONST_TIME_EN
    assign p_add = corr_q ? p_q[DIGIT-1:0] : '0;
`else
    assign p_add = p_q[DIGIT-1:0];
`endif

    // Extending to DIGIT+1 bits makes the top bit the borrow / carry out.
    assign sub_t = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, brw_q};
    assign add_t = {1'b0, res_q[DIGIT-1:0]} + {1'b0, p_add}
                 + {{DIGIT{1'b0}}, brw_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        corr_d  = corr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    p_d     = p;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    corr_d  = 1'b0;
                    state_d = S_SUB;
                end
            end

            S_SUB: begin
                // Result enters from the MSB end; after N digits the first
                // digit computed has reached the LSB position.
                res_d                  = res_q >> DIGIT;
                res_d[WIDTH-1 -: DIGIT] = sub_t[DIGIT-1:0];
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                brw_d = sub_t[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    corr_d = sub_t[DIGIT];
`ifdef MODSUB_CONST_TIME_EN
                    brw_d   = 1'b0;
                    state_d = S_FIX;
`else
                    if (sub_t[DIGIT]) begin
                        brw_d   = 1'b0;
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_FIX: begin
                // The result register is rotated through once more while p
                // rotates alongside it so their digits stay aligned.
                res_d                  = res_q >> DIGIT;
                res_d[WIDTH-1 -: DIGIT] = add_t[DIGIT-1:0];
                p_d   = (p_q >> DIGIT) | (p_q << (WIDTH - DIGIT));
                brw_d = add_t[DIGIT];   // last carry-out is simply dropped
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end

            default: begin  // S_DONE
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            corr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            corr_q  <= corr_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d         = res_q;
    assign corr      = corr_q;

endmodule
